// File: rtl/projectile_pool.sv
// rtl/projectile_pool.sv - fixed-size pool of vertically travelling projectiles with edge-triggered firing
module projectile_pool #(
    parameter int NP       = 4,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 3,
    parameter int DIR      = 0,
    parameter int PROJ_W   = 2,
    parameter int PROJ_H   = 8,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      FireReq,
    input  logic [9:0]                OriginX,
    input  logic [9:0]                OriginY,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [NP-1:0]             ProjColl,
    output logic [NP-1:0]             ProjOn,
    output logic [9:0]                ProjDistX,
    output logic [9:0]                ProjDistY,
    output logic [NP-1:0]             ActiveMask,
    output logic [$clog2(NP+1)-1:0]   ActiveCount,
    output logic                      FireAck
);

    localparam int IW = (NP > 1) ? $clog2(NP) : 1;
    localparam int CW = $clog2(NP + 1);
    localparam logic [10:0] LO_LIM = 11'(Y_MIN + SPEED);
    localparam logic [10:0] HI_LIM = 11'(Y_MAX);
    localparam logic [10:0] SPD11  = 11'(SPEED);
    localparam logic [10:0] W11    = 11'(PROJ_W);
    localparam logic [10:0] H11    = 11'(PROJ_H);

    logic [NP-1:0]       active_q, active_d;
    logic [NP-1:0][9:0]  x_q, x_d;
    logic [NP-1:0][9:0]  y_q, y_d;
    logic [5:0]          cool_q, cool_d;
    logic                fire_prev_q, fire_prev_d;
    logic                armed_q, armed_d;
    logic                fire_ack_q, fire_ack_d;

    logic                any_idle;
    logic [IW-1:0]       alloc_idx;
    logic                fire_event;
    logic                accept;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            active_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cool_q      <= '0;
            fire_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            fire_ack_q  <= 1'b0;
        end else begin
            active_q    <= active_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cool_q      <= cool_d;
            fire_prev_q <= fire_prev_d;
            armed_q     <= armed_d;
            fire_ack_q  <= fire_ack_d;
        end
    end

    // Allocation looks only at registered state, so slots freed this cycle stay unavailable.
    always_comb begin
        any_idle  = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < NP; i++) begin
            if (!active_q[i] && !any_idle) begin
                any_idle  = 1'b1;
                alloc_idx = IW'(i);
            end
        end
    end

    // A button held across reset must be released once before it can fire.
    always_comb begin
        fire_prev_d = FireReq;
        armed_d     = armed_q | ~FireReq;
        fire_event  = FireReq & ~fire_prev_q & armed_q;
        accept      = fire_event && (cool_q == 6'd0) && any_idle;
        fire_ack_d  = accept;
        if (accept) begin
            cool_d = 6'(COOLDOWN);
        end else if (cool_q != 6'd0) begin
            cool_d = cool_q - 6'd1;
        end else begin
            cool_d = 6'd0;
        end
    end

    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        for (int i = 0; i < NP; i++) begin
            if (active_q[i]) begin
                if (ProjColl[i]) begin
                    active_d[i] = 1'b0;
                end else if (DIR == 0) begin
                    if ({1'b0, y_q[i]} < LO_LIM) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] - 10'(SPEED);
                    end
                end else begin
                    if (({1'b0, y_q[i]} + SPD11) > HI_LIM) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] + 10'(SPEED);
                    end
                end
            end else if (accept && (alloc_idx == IW'(i))) begin
                active_d[i] = 1'b1;
                x_d[i]      = OriginX;
                y_d[i]      = OriginY;
            end
        end
    end

    // Box tests are done in 11 bits so a box near the right/bottom edge cannot wrap.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            ProjOn[i] = active_q[i]
                      && (DrawX >= x_q[i]) && ({1'b0, DrawX} < ({1'b0, x_q[i]} + W11))
                      && (DrawY >= y_q[i]) && ({1'b0, DrawY} < ({1'b0, y_q[i]} + H11));
        end
    end

    always_comb begin
        logic found;
        found     = 1'b0;
        ProjDistX = 10'd0;
        ProjDistY = 10'd0;
        for (int i = 0; i < NP; i++) begin
            if (ProjOn[i] && !found) begin
                found     = 1'b1;
                ProjDistX = DrawX - x_q[i];
                ProjDistY = DrawY - y_q[i];
            end
        end
    end

    always_comb begin
        ActiveCount = '0;
        for (int i = 0; i < NP; i++) begin
            ActiveCount = ActiveCount + CW'(active_q[i]);
        end
    end

    assign ActiveMask = active_q;
    assign FireAck    = fire_ack_q;

endmodule

// File: tb/tb_projectile_pool.sv
// tb/tb_projectile_pool.sv - directed self-checking bench for projectile_pool (upward and downward instances)
module tb_projectile_pool;

    logic       frame_clk;
    logic       Reset;
    logic       FireReq, FireReq2;
    logic [9:0] OriginX, OriginY, OriginY2;
    logic [9:0] DrawX, DrawY, DrawY2;
    logic [3:0] ProjColl, ProjColl2;
    logic [3:0] ProjOn, ProjOn2;
    logic [9:0] ProjDistX, ProjDistY, ProjDistX2, ProjDistY2;
    logic [3:0] ActiveMask, ActiveMask2;
    logic [2:0] ActiveCount, ActiveCount2;
    logic       FireAck, FireAck2;

    int n_tests = 0;
    int n_fail  = 0;

    projectile_pool dut (
        .frame_clk(frame_clk), .Reset(Reset), .FireReq(FireReq),
        .OriginX(OriginX), .OriginY(OriginY), .DrawX(DrawX), .DrawY(DrawY),
        .ProjColl(ProjColl), .ProjOn(ProjOn), .ProjDistX(ProjDistX), .ProjDistY(ProjDistY),
        .ActiveMask(ActiveMask), .ActiveCount(ActiveCount), .FireAck(FireAck)
    );

    projectile_pool #(.DIR(1)) dut_dn (
        .frame_clk(frame_clk), .Reset(Reset), .FireReq(FireReq2),
        .OriginX(OriginX), .OriginY(OriginY2), .DrawX(DrawX), .DrawY(DrawY2),
        .ProjColl(ProjColl2), .ProjOn(ProjOn2), .ProjDistX(ProjDistX2), .ProjDistY(ProjDistY2),
        .ActiveMask(ActiveMask2), .ActiveCount(ActiveCount2), .FireAck(FireAck2)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic fire_edge();
        FireReq = 1'b0;
        tick();
        FireReq = 1'b1;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; FireReq = 1'b1; FireReq2 = 1'b0;
        OriginX = 10'd100; OriginY = 10'd400; OriginY2 = 10'd468;
        DrawX = 10'd100; DrawY = 10'd400; DrawY2 = 10'd0;
        ProjColl = 4'd0; ProjColl2 = 4'd0;
        tick(); tick();
        check("rst_mask", ActiveMask, 4'b0000);
        check("rst_count", ActiveCount, 3'd0);
        check("rst_ack", FireAck, 1'b0);
        check("rst_on", ProjOn, 4'b0000);
        check("rst_dx", ProjDistX, 10'd0);
        check("rst_dy", ProjDistY, 10'd0);

        // FireReq held high through reset release must not fire
        Reset = 1'b0;
        tick(); tick();
        check("held_thru_rst_count", ActiveCount, 3'd0);
        check("held_thru_rst_ack", FireAck, 1'b0);

        // First shot at (100,400), then moving up by 4 per cycle
        fire_edge();
        check("shot0_ack", FireAck, 1'b1);
        check("shot0_mask", ActiveMask, 4'b0001);
        check("shot0_count", ActiveCount, 3'd1);
        DrawX = 10'd101; DrawY = 10'd402; #1;
        check("shot0_on", ProjOn, 4'b0001);
        check("shot0_dx", ProjDistX, 10'd1);
        check("shot0_dy", ProjDistY, 10'd2);
        tick();
        check("ack_one_cycle", FireAck, 1'b0);
        DrawY = 10'd398; #1;
        check("y396_on", ProjOn, 4'b0001);
        check("y396_dy", ProjDistY, 10'd2);
        tick();
        DrawY = 10'd394; #1;
        check("y392_dy", ProjDistY, 10'd2);
        check("held_no_refire", ActiveCount, 3'd1);

        // Fill remaining slots with edges 4 cycles apart, fifth edge dropped
        fire_edge();
        check("fill1_ack", FireAck, 1'b1);
        check("fill1_mask", ActiveMask, 4'b0011);
        repeat (2) tick();
        fire_edge();
        check("fill2_mask", ActiveMask, 4'b0111);
        repeat (2) tick();
        fire_edge();
        check("fill3_mask", ActiveMask, 4'b1111);
        check("fill3_count", ActiveCount, 3'd4);
        repeat (2) tick();
        fire_edge();
        check("full_drop_ack", FireAck, 1'b0);
        check("full_drop_mask", ActiveMask, 4'b1111);
        check("full_drop_count", ActiveCount, 3'd4);

        // Collision on slot1 together with a fire edge: freed slot not reused this cycle
        FireReq = 1'b0;
        tick();
        FireReq = 1'b1; ProjColl = 4'b0010;
        tick();
        ProjColl = 4'b0000;
        check("coll_fire_ack", FireAck, 1'b0);
        check("coll_fire_mask", ActiveMask, 4'b1101);
        check("coll_fire_count", ActiveCount, 3'd3);
        OriginY = 10'd200;
        fire_edge();
        check("refill1_ack", FireAck, 1'b1);
        check("refill1_mask", ActiveMask, 4'b1111);
        DrawX = 10'd100; DrawY = 10'd203; #1;
        check("refill1_on", ProjOn, 4'b0010);
        check("refill1_dy", ProjDistY, 10'd3);

        // Cooldown: edges 2 cycles apart, every second one rejected
        Reset = 1'b1; FireReq = 1'b0;
        tick();
        Reset = 1'b0; OriginY = 10'd400;
        fire_edge();
        check("cd_e0_ack", FireAck, 1'b1);
        fire_edge();
        check("cd_e1_ack", FireAck, 1'b0);
        check("cd_e1_count", ActiveCount, 3'd1);
        fire_edge();
        check("cd_e2_ack", FireAck, 1'b1);
        check("cd_e2_count", ActiveCount, 3'd2);
        fire_edge();
        check("cd_e3_ack", FireAck, 1'b0);
        check("cd_e3_count", ActiveCount, 3'd2);

        // Hit test and lowest-index selection
        Reset = 1'b1; FireReq = 1'b0;
        tick();
        Reset = 1'b0; OriginX = 10'd100; OriginY = 10'd300;
        fire_edge();
        DrawX = 10'd101; DrawY = 10'd305; #1;
        check("hit_on", ProjOn, 4'b0001);
        check("hit_dx", ProjDistX, 10'd1);
        check("hit_dy", ProjDistY, 10'd5);
        OriginY = 10'd50;
        repeat (2) tick();
        fire_edge();
        OriginX = 10'd99; OriginY = 10'd265;
        repeat (2) tick();
        fire_edge();
        DrawX = 10'd100; DrawY = 10'd270; #1;
        check("overlap_on", ProjOn, 4'b0101);
        check("overlap_dx", ProjDistX, 10'd0);
        check("overlap_dy", ProjDistY, 10'd2);
        ProjColl = 4'b0001;
        tick();
        ProjColl = 4'b0000;
        DrawY = 10'd266; #1;
        check("after_coll_on", ProjOn, 4'b0100);
        check("after_coll_dx", ProjDistX, 10'd1);
        check("after_coll_dy", ProjDistY, 10'd5);
        check("after_coll_mask", ActiveMask, 4'b0110);

        // Reset mid-flight overrides a simultaneous fire edge and collision
        Reset = 1'b1; FireReq = 1'b1; ProjColl = 4'b0100;
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        ProjColl = 4'b0000;
        check("midrst_mask", ActiveMask, 4'b0000);
        check("midrst_count", ActiveCount, 3'd0);
        check("midrst_ack", FireAck, 1'b0);
        check("midrst_on", ProjOn, 4'b0000);
        check("midrst_dy", ProjDistY, 10'd0);
        Reset = 1'b0;
        tick();
        check("midrst_held_count", ActiveCount, 3'd0);

        // Upward boundary: Y=3 retires instead of wrapping
        OriginX = 10'd100; OriginY = 10'd7;
        fire_edge();
        DrawX = 10'd100; DrawY = 10'd7; #1;
        check("up_y7_dy", ProjDistY, 10'd0);
        tick();
        DrawY = 10'd3; #1;
        check("up_y3_on", ProjOn, 4'b0001);
        check("up_y3_dy", ProjDistY, 10'd0);
        tick();
        check("up_retire_mask", ActiveMask, 4'b0000);
        DrawY = 10'd1022; #1;
        check("up_no_wrap_on", ProjOn, 4'b0000);

        // Downward boundary: Y=476 retires instead of moving past 479
        FireReq2 = 1'b0;
        tick();
        FireReq2 = 1'b1;
        tick();
        check("dn_ack", FireAck2, 1'b1);
        tick(); tick();
        DrawY2 = 10'd476; #1;
        check("dn_y476_on", ProjOn2, 4'b0001);
        check("dn_y476_dy", ProjDistY2, 10'd0);
        tick();
        check("dn_retire_mask", ActiveMask2, 4'b0000);
        check("dn_retire_count", ActiveCount2, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
